dtmf_tone_gen: RTL and testbench
================================

DTMF_TONE_GEN -- requirements
Module: dtmf_tone_gen

Interface
REQ-001 SHALL provide parameter TONE_CYCLES, default 50000, tone burst length in clk_1m_in cycles (legal range 1..131071).
REQ-002 SHALL provide parameter GAP_CYCLES, default 50000, inter-digit silence length in clk_1m_in cycles (legal range 1..131071).
REQ-003 SHALL have port clk_1m_in  input  1  1 MHz system clock; all state on rising edge.
REQ-004 SHALL have port reset_b  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port key_code  input  4  digit index; row = key_code[3:2], column = key_code[1:0].
REQ-006 SHALL have port key_valid  input  1  key_code valid request.
REQ-007 SHALL have port key_ready  output  1  block can accept a digit.
REQ-008 SHALL have port row_tone  output  1  low-group square wave.
REQ-009 SHALL have port col_tone  output  1  high-group square wave.
REQ-010 SHALL have port tone_active  output  1  high while in TONE state.
REQ-011 SHALL have port dtmf_level  output  2  row_tone + col_tone, unsigned (0..2).

Function
REQ-012 FSM states SHALL be IDLE, TONE, GAP; key_ready = 1 only in IDLE.
REQ-013 Accept SHALL occur on a rising edge with key_valid = 1 and key_ready = 1: key_code latched, state -> TONE on that edge.
REQ-014 key_valid while not in IDLE SHALL be ignored; no queuing; key_code changes after accept SHALL not affect the burst.
REQ-015 Row half-period divisors SHALL be 717, 649, 586, 531 for row 0..3 (697/770/852/941 Hz).
REQ-016 Column half-period divisors SHALL be 413, 374, 338, 306 for column 0..3 (1209/1336/1477/1633 Hz).
REQ-017 Each tone SHALL use its own 10-bit counter, cleared to 0 on accept; output toggles and counter returns to 0 when counter = divisor-1, giving exact period 2*divisor cycles.
REQ-018 row_tone and col_tone SHALL be 0 on the accept edge and SHALL first toggle to 1 exactly divisor cycles after entering TONE.
REQ-019 A 17-bit duration counter SHALL clear on each state entry; TONE SHALL last exactly TONE_CYCLES cycles, then -> GAP.
REQ-020 On leaving TONE, row_tone and col_tone SHALL be forced to 0 and both tone counters held at 0 outside TONE.
REQ-021 GAP SHALL last exactly GAP_CYCLES cycles, then -> IDLE (key_ready = 1 the following cycle).
REQ-022 dtmf_level SHALL be registered-consistent with row_tone/col_tone in the same cycle (combinational sum of the registered tones).
REQ-023 tone_active SHALL be a registered decode of state == TONE.

Reset
REQ-024 While reset_b = 0: state IDLE, key_ready 1, row_tone 0, col_tone 0, tone_active 0, dtmf_level 0, all counters 0, latched code 0.
REQ-025 Reset asserted mid-TONE or mid-GAP SHALL abort immediately (asynchronously) to the reset values; no partial burst resumes after release.
REQ-026 First accept SHALL be possible on the first rising edge after reset_b deasserts.

Configuration
REQ-027 Macro DTMF_GAP_EN: when defined, GAP state exists per REQ-021.
REQ-028 Without DTMF_GAP_EN: GAP_CYCLES unused, TONE -> IDLE directly after TONE_CYCLES; key_ready = 1 the next cycle; all other behaviour identical.

Verification
REQ-029 Reset then key_code=4'h0, key_valid 1 cycle -> row_tone period 1434 cycles, col_tone period 826 cycles, tone_active high 50000 cycles.
REQ-030 key_code=4'hF -> row period 1062, col period 612 cycles; dtmf_level equals row_tone+col_tone every cycle, reaches 2.
REQ-031 key_valid held high continuously with DTMF_GAP_EN -> accepts spaced exactly TONE_CYCLES+GAP_CYCLES+1 cycles apart; intermediate key_code changes ignored.
REQ-032 Same as REQ-031 without DTMF_GAP_EN -> accepts spaced TONE_CYCLES+1 cycles; tones 0 between bursts.
REQ-033 reset_b pulsed low 1000 cycles into TONE -> all outputs at reset values immediately; key_ready 1; new digit 4'h5 then yields 770/1336 Hz periods (1298/748).
REQ-034 TONE_CYCLES=1, GAP_CYCLES=1 -> tone_active high exactly 1 cycle, tones stay 0, key_ready returns after 2 cycles in non-IDLE states.

Source files
------------

// File: rtl/dtmf_tone_gen.sv
// DTMF dual-tone square-wave generator: one key press yields a TONE burst, then an optional GAP.
// Build macro DTMF_GAP_EN enables the inter-digit GAP state; without it TONE returns straight to IDLE.
module dtmf_tone_gen #(
   parameter int unsigned TONE_CYCLES = 50000,
   parameter int unsigned GAP_CYCLES  = 50000
) (
   input  logic       clk_1m_in,
   input  logic       reset_b,
   input  logic [3:0] key_code,
   input  logic       key_valid,
   output logic       key_ready,
   output logic       row_tone,
   output logic       col_tone,
   output logic       tone_active,
   output logic [1:0] dtmf_level
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TONE = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic [16:0] TONE_LAST = 17'(TONE_CYCLES - 1);
   localparam logic [16:0] GAP_LAST  = 17'(GAP_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  code_q, code_d;
   logic [16:0] dur_q, dur_d;
   logic [9:0]  row_cnt_q, row_cnt_d;
   logic [9:0]  col_cnt_q, col_cnt_d;
   logic        row_q, row_d;
   logic        col_q, col_d;
   logic        act_q, act_d;
   logic [9:0]  row_last;
   logic [9:0]  col_last;

   // Terminal counts are divisor-1 so each half-period is exactly the divisor.
   function automatic logic [9:0] row_div_last(input logic [1:0] row);
      logic [9:0] last;
      case (row)
         2'd0:    last = 10'd716;
         2'd1:    last = 10'd648;
         2'd2:    last = 10'd585;
         default: last = 10'd530;
      endcase
      return last;
   endfunction

   function automatic logic [9:0] col_div_last(input logic [1:0] col);
      logic [9:0] last;
      case (col)
         2'd0:    last = 10'd412;
         2'd1:    last = 10'd373;
         2'd2:    last = 10'd337;
         default: last = 10'd305;
      endcase
      return last;
   endfunction

   assign row_last = row_div_last(code_q[3:2]);
   assign col_last = col_div_last(code_q[1:0]);

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      dur_d   = dur_q + 17'd1;
      case (state_q)
         IDLE: begin
            dur_d = '0;
            if (key_valid) begin
               state_d = TONE;
               code_d  = key_code;
            end
         end
         TONE: begin
            if (dur_q == TONE_LAST) begin
               dur_d = '0;
`ifdef DTMF_GAP_EN
               state_d = GAP;
`else
               state_d = IDLE;
`endif
            end
         end
         GAP: begin
            if (dur_q == GAP_LAST) begin
               dur_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            dur_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // Tone dividers only run while staying in TONE; entry and exit both leave them cleared and low.
   always_comb begin
      row_cnt_d = '0;
      col_cnt_d = '0;
      row_d     = 1'b0;
      col_d     = 1'b0;
      if (state_q == TONE && state_d == TONE) begin
         row_cnt_d = row_cnt_q + 10'd1;
         row_d     = row_q;
         if (row_cnt_q == row_last) begin
            row_cnt_d = '0;
            row_d     = ~row_q;
         end
         col_cnt_d = col_cnt_q + 10'd1;
         col_d     = col_q;
         if (col_cnt_q == col_last) begin
            col_cnt_d = '0;
            col_d     = ~col_q;
         end
      end
   end

   assign act_d = (state_d == TONE);

   always_ff @(posedge clk_1m_in or negedge reset_b) begin
      if (!reset_b) begin
         state_q   <= IDLE;
         code_q    <= '0;
         dur_q     <= '0;
         row_cnt_q <= '0;
         col_cnt_q <= '0;
         row_q     <= 1'b0;
         col_q     <= 1'b0;
         act_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         code_q    <= code_d;
         dur_q     <= dur_d;
         row_cnt_q <= row_cnt_d;
         col_cnt_q <= col_cnt_d;
         row_q     <= row_d;
         col_q     <= col_d;
         act_q     <= act_d;
      end
   end

   assign key_ready   = (state_q == IDLE);
   assign row_tone    = row_q;
   assign col_tone    = col_q;
   assign tone_active = act_q;
   assign dtmf_level  = {1'b0, row_q} + {1'b0, col_q};

endmodule

// File: tb/tb_dtmf_tone_gen.sv
// Randomized bench for dtmf_tone_gen: two instances (long burst and 1-cycle burst) against a
// timeline model that derives every output from the edge count since the last accepted key.
module tb_dtmf_tone_gen;

   localparam int T0 = 3000;
   localparam int G0 = 500;
   localparam int T1 = 1;
   localparam int G1 = 1;

   logic       clk = 1'b0;
   logic       reset_b = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = 4'h0;
   logic [1:0] ready_w, row_w, col_w, act_w;
   logic [1:0] lvl_w [2];

   always #5 clk = ~clk;

   dtmf_tone_gen #(.TONE_CYCLES(T0), .GAP_CYCLES(G0)) u_dut0 (
      .clk_1m_in(clk), .reset_b(reset_b), .key_code(key_code), .key_valid(key_valid),
      .key_ready(ready_w[0]), .row_tone(row_w[0]), .col_tone(col_w[0]),
      .tone_active(act_w[0]), .dtmf_level(lvl_w[0]));

   dtmf_tone_gen #(.TONE_CYCLES(T1), .GAP_CYCLES(G1)) u_dut1 (
      .clk_1m_in(clk), .reset_b(reset_b), .key_code(key_code), .key_valid(key_valid),
      .key_ready(ready_w[1]), .row_tone(row_w[1]), .col_tone(col_w[1]),
      .tone_active(act_w[1]), .dtmf_level(lvl_w[1]));

   int n_cmp = 0;
   int n_bad = 0;
   int edge_n = 0;
   int tlen[2] = '{T0, T1};
`ifdef DTMF_GAP_EN
   int blen[2] = '{T0 + G0, T1 + G1};
`else
   int blen[2] = '{T0, T1};
`endif
   int rdiv[4] = '{717, 649, 586, 531};
   int cdiv[4] = '{413, 374, 338, 306};
   bit         busy[2];
   int         acc[2];
   logic [3:0] mcode[2];
   bit         mready0 = 1'b1;
   bit         seen2 = 1'b0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         if (n_bad <= 30)
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, obs, exp, edge_n);
      end
   endtask

   // Advance the model by the rising edge that just occurred, then compare both instances.
   task automatic step();
      int k, er, ea, erow, ecol;
      edge_n++;
      for (int d = 0; d < 2; d++) begin
         if (reset_b && key_valid && (!busy[d] || edge_n > acc[d] + blen[d])) begin
            busy[d]  = 1'b1;
            acc[d]   = edge_n;
            mcode[d] = key_code;
         end
         k    = edge_n - acc[d];
         ea   = (busy[d] && k < tlen[d]) ? 1 : 0;
         er   = (!busy[d] || k >= blen[d]) ? 1 : 0;
         erow = ea ? (k / rdiv[mcode[d][3:2]]) % 2 : 0;
         ecol = ea ? (k / cdiv[mcode[d][1:0]]) % 2 : 0;
         chk($sformatf("key_ready%0d", d), int'(ready_w[d]), er);
         chk($sformatf("tone_active%0d", d), int'(act_w[d]), ea);
         chk($sformatf("row_tone%0d", d), int'(row_w[d]), erow);
         chk($sformatf("col_tone%0d", d), int'(col_w[d]), ecol);
         chk($sformatf("dtmf_level%0d", d), int'(lvl_w[d]), erow + ecol);
         if (d == 0) mready0 = (er != 0);
      end
      if (lvl_w[0] == 2'd2) seen2 = 1'b1;
   endtask

   task automatic tick(input bit kv, input logic [3:0] kc);
      @(negedge clk);
      step();
      key_valid = kv;
      key_code  = kc;
   endtask

   task automatic drain();
      for (int i = 0; i < 5000 && !mready0; i++) tick(1'b0, 4'($urandom));
      chk("drain_to_idle", int'(mready0), 1);
   endtask

   task automatic check_reset_now();
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("async_ready%0d", d), int'(ready_w[d]), 1);
         chk($sformatf("async_row%0d", d), int'(row_w[d]), 0);
         chk($sformatf("async_col%0d", d), int'(col_w[d]), 0);
         chk($sformatf("async_active%0d", d), int'(act_w[d]), 0);
         chk($sformatf("async_level%0d", d), int'(lvl_w[d]), 0);
         busy[d] = 1'b0;
      end
   endtask

   initial begin
      busy[0] = 1'b0; busy[1] = 1'b0;
      acc[0] = 0; acc[1] = 0;
      mcode[0] = 4'h0; mcode[1] = 4'h0;
      key_valid = 1'b1;
      key_code  = 4'h0;
      // Valid held during reset must not be taken; the first edge after release must accept digit 0.
      repeat (4) tick(1'b1, 4'h0);
      reset_b = 1'b1;
      tick(1'b0, 4'($urandom));
      repeat (3600) tick(($urandom_range(0, 999) == 0), 4'($urandom));
      drain();
      tick(1'b1, 4'hF);
      repeat (3600) tick(1'b0, 4'($urandom));
      repeat (8000) tick(1'b1, 4'($urandom));
      repeat (6000) tick(($urandom_range(0, 9) == 0), 4'($urandom));
      drain();
      tick(1'b1, 4'h5);
      repeat (1000) tick(1'b0, 4'($urandom));
      reset_b = 1'b0;
      #1;
      check_reset_now();
      repeat (3) tick(1'b0, 4'($urandom));
      tick(1'b1, 4'h5);
      reset_b = 1'b1;
      tick(1'b0, 4'($urandom));
      repeat (3600) tick(($urandom_range(0, 499) == 0), 4'($urandom));
      chk("level_reaches_2", int'(seen2), 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
